// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong buffer read and write controllers.
package pingpong_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Address width for a buffer of the given depth, never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pp_rd_skid.sv
// Two-entry output FIFO of {last, data} placed behind a latency-1 memory read port.
module pp_rd_skid
   import pingpong_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head_data,
   output logic             head_last
);

   logic [WIDTH-1:0] data_r [2];
   logic [1:0]       last_r;
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign pop_ok_s  = pop && (count_r != 2'd0);
   assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);

   // Entry storage, read/write pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r[0] <= '0;
         data_r[1] <= '0;
         last_r    <= 2'b00;
         wr_ptr_r  <= 1'b0;
         rd_ptr_r  <= 1'b0;
         count_r   <= 2'd0;
      end else begin
         if (push_ok_s) begin
            data_r[wr_ptr_r] <= push_data;
            last_r[wr_ptr_r] <= push_last;
            wr_ptr_r         <= ~wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign count     = count_r;
   assign head_data = data_r[rd_ptr_r];
   assign head_last = last_r[rd_ptr_r];

endmodule

// File: rtl/pingpong_rd_ctrl.sv
// Read-side ping-pong controller: sweeps a filled buffer into a valid/ready stream.
// Defining PINGPONG_RD_LEN_EN adds a per-buffer length input rd_len.
module pingpong_rd_ctrl
   import pingpong_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int DEPTH      = 16,
   localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  buf_full,
`ifdef PINGPONG_RD_LEN_EN
   input  logic [ADDR_WIDTH:0]   rd_len,
`endif
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WIDTH-1:0]      rd_data,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  rd_done,
   output logic                  busy,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_N  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   ZERO_N   = (ADDR_WIDTH+1)'(0);
   localparam logic [ADDR_WIDTH:0]   ONE_N    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state_r;
   logic [ADDR_WIDTH-1:0] rd_addr_r;
   logic                  busy_r;
   logic                  rd_done_r;
   logic                  overflow_r;
   logic                  pending_r;
   logic                  inflight_r;
   logic                  inflight_last_r;
   logic [1:0]            fifo_count_s;
   logic [WIDTH-1:0]      head_data_s;
   logic                  head_last_s;
   logic [ADDR_WIDTH:0]   n_s;
   logic [2:0]            occupancy_s;
   logic                  pop_s;
   logic                  issue_s;
   logic                  last_issue_s;
   logic                  finish_s;
   logic                  start_s;

`ifdef PINGPONG_RD_LEN_EN
   logic [ADDR_WIDTH:0] len_in_s;
   logic [ADDR_WIDTH:0] len_r;
   logic [ADDR_WIDTH:0] pend_len_r;

   assign len_in_s = (rd_len > DEPTH_N) ? DEPTH_N : rd_len;
   assign n_s      = len_r;

   // Buffer length: taken at start, or parked alongside the pending flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_r      <= ZERO_N;
         pend_len_r <= ZERO_N;
      end else begin
         if (start_s) begin
            len_r <= pending_r ? pend_len_r : len_in_s;
         end
         if (buf_full && (pending_r == start_s)) begin
            pend_len_r <= len_in_s;
         end
      end
   end
`else
   assign n_s = DEPTH_N;
`endif

   assign pop_s        = m_valid && m_ready;
   // A word leaving the FIFO this cycle frees its slot for the next issue.
   assign occupancy_s  = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
   assign last_issue_s = ({1'b0, rd_addr_r} == (n_s - ONE_N));
   assign issue_s      = (state_r == READ) && (n_s != ZERO_N) && (occupancy_s < 3'd2);
   assign finish_s     = ((state_r == DRAIN) && pop_s && head_last_s) ||
                         ((state_r == READ) && (n_s == ZERO_N));
   assign start_s      = (pending_r || buf_full) && ((state_r == IDLE) || finish_s);

   // Sequencer: start a buffer, sweep the read address, wait for the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         rd_addr_r <= '0;
         busy_r    <= 1'b0;
         rd_done_r <= 1'b0;
      end else begin
         rd_done_r <= finish_s;
         if (start_s) begin
            state_r   <= READ;
            rd_addr_r <= '0;
            busy_r    <= 1'b1;
         end else if (finish_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               READ: begin
                  if (issue_s && last_issue_s) begin
                     state_r <= DRAIN;
                  end else if (issue_s) begin
                     rd_addr_r <= rd_addr_r + ADDR_ONE;
                  end
               end
               IDLE, DRAIN: state_r <= state_r;
               default:     state_r <= IDLE;
            endcase
         end
      end
   end

   // Notification bookkeeping: one pending slot, sticky overflow beyond it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r  <= 1'b0;
         overflow_r <= 1'b0;
      end else if (start_s) begin
         pending_r <= pending_r && buf_full;
      end else if (buf_full) begin
         if (pending_r) begin
            overflow_r <= 1'b1;
         end else begin
            pending_r <= 1'b1;
         end
      end
   end

   // Read pipeline: the word issued now arrives on rd_data next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
      end else begin
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s && last_issue_s;
      end
   end

   pp_rd_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_r),
      .push_data (rd_data),
      .push_last (inflight_last_r),
      .pop       (pop_s),
      .count     (fifo_count_s),
      .head_data (head_data_s),
      .head_last (head_last_s)
   );

   assign rd_addr  = rd_addr_r;
   assign m_valid  = (fifo_count_s != 2'd0);
   assign m_data   = head_data_s;
   assign m_last   = m_valid && head_last_s;
   assign rd_done  = rd_done_r;
   assign busy     = busy_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_pingpong_rd_ctrl.sv
// Self-checking bench for pingpong_rd_ctrl: buffer memory model plus stream scoreboard.
`timescale 1ns/1ps
module tb_pingpong_rd_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             buf_full = 1'b0;
   logic             m_ready = 1'b0;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] m_data;
   logic             m_valid, m_last, rd_done, busy, overflow;
`ifdef PINGPONG_RD_LEN_EN
   logic [AW:0]      rd_len = 5'd16;
`endif

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH:0]   got_q [$];
   logic [WIDTH:0]   exp_q [$];
   int ready_mode = 0;
   int rp = 0;
   logic [3:0] pat = 4'b1001;

   int cyc = 0, bf_cyc = -1, first_valid_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
   int buf_beats = 0, max_lead = 0, stall_viol = 0;
   logic prev_stall = 1'b0;
   logic prev_last = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   pingpong_rd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .buf_full (buf_full),
`ifdef PINGPONG_RD_LEN_EN
      .rd_len   (rd_len),
`endif
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last),
      .rd_done  (rd_done),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Buffer read port with one cycle of latency.
   always @(posedge clk) rd_data <= mem[rd_addr];

   // Stream observer on the falling edge: records beats, timing and stall behaviour.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_stall = 1'b0;
            buf_beats  = 0;
         end else begin
            if (busy && (int'(rd_addr) - buf_beats > max_lead)) max_lead = int'(rd_addr) - buf_beats;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
            if (buf_full) bf_cyc = cyc;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rd_done) done_cyc = cyc;
            if (m_valid && m_ready) begin
               got_q.push_back({m_last, m_data});
               buf_beats++;
               if (m_last) begin
                  last_beat_cyc = cyc;
                  buf_beats = 0;
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic bf);
      buf_full = bf;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       begin m_ready = pat[rp % 4]; rp++; end
         2:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
      @(posedge clk);
      #1;
      buf_full = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0);
      rst = 1'b0;
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      first_valid_cyc = -1;
      last_beat_cyc   = -1;
      done_cyc        = -1;
      max_lead        = 0;
      stall_viol      = 0;
   endtask

   task automatic fill_mem(input bit seq);
      for (int i = 0; i < DEPTH; i++) mem[i] = seq ? WIDTH'(i) : WIDTH'($urandom);
   endtask

   // Reference model: a started buffer of n words yields mem[0..n-1], last on word n-1.
   task automatic expect_buffer(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[i]});
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({m_valid, m_last, rd_done, busy, overflow} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got v/l/d/b/o=%b required 00000", {m_valid, m_last, rd_done, busy, overflow});
      end
      checks++;
      if ({rd_addr, m_data} !== 12'h000) begin
         errors++;
         $display("FAIL reset_data: got rd_addr=%0d m_data=%0h required 0/0", rd_addr, m_data);
      end
   endtask

   task automatic test_single();
      int dones = 0;
      do_reset(); fill_mem(1'b1); clear_obs(); ready_mode = 0;
      expect_buffer(DEPTH);
      step(1'b1);
      for (int c = 0; c < 60 && dones < 1; c++) begin step(1'b0); if (rd_done) dones++; end
      repeat (3) step(1'b0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d beats required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (first_valid_cyc - bf_cyc !== 3) begin errors++; $display("FAIL single_latency: got %0d required 3", first_valid_cyc - bf_cyc); end
      checks++;
      if (last_beat_cyc - first_valid_cyc !== DEPTH - 1) begin errors++; $display("FAIL single_rate: got span %0d required %0d", last_beat_cyc - first_valid_cyc, DEPTH - 1); end
      checks++;
      if (done_cyc - last_beat_cyc !== 1) begin errors++; $display("FAIL single_done_lat: got %0d required 1", done_cyc - last_beat_cyc); end
      checks++;
      if (dones !== 1 || busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL single_end: got dones=%0d busy=%b ovf=%b required 1/0/0", dones, busy, overflow); end
   endtask

   task automatic test_backpressure();
      int dones = 0;
      do_reset(); fill_mem(1'b0); clear_obs(); ready_mode = 1; rp = 0;
      expect_buffer(DEPTH);
      step(1'b1);
      for (int c = 0; c < 150 && dones < 1; c++) begin step(1'b0); if (rd_done) dones++; end
      repeat (3) step(1'b0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d beats required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_viol); end
      checks++;
      if (max_lead > 2) begin errors++; $display("FAIL bp_lead: got lead %0d required <=2", max_lead); end
      checks++;
      if (dones !== 1) begin errors++; $display("FAIL bp_done: got %0d rd_done pulses required 1", dones); end
   endtask

   task automatic test_back_to_back();
      int dones = 0, gap = 0;
      do_reset(); fill_mem(1'b0); clear_obs(); ready_mode = 0;
      expect_buffer(DEPTH); expect_buffer(DEPTH);
      step(1'b1);
      for (int c = 0; c < 40 && got_q.size() < 5; c++) step(1'b0);
      step(1'b1);
      if (rd_done) dones++;
      for (int c = 0; c < 100 && dones < 2; c++) begin
         step(1'b0);
         if (rd_done) dones++;
         if (!busy && dones < 2) gap++;
      end
      repeat (3) step(1'b0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d beats required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (gap !== 0 || dones !== 2) begin errors++; $display("FAIL b2b_busy: got idle_cycles=%0d dones=%0d required 0/2", gap, dones); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b required 0", overflow); end
   endtask

   task automatic test_overflow();
      int dones = 0;
      do_reset(); fill_mem(1'b0); clear_obs(); ready_mode = 0;
      expect_buffer(DEPTH); expect_buffer(DEPTH);
      step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
      for (int c = 0; c < 100 && dones < 2; c++) begin step(1'b0); if (rd_done) dones++; end
      for (int c = 0; c < 20; c++) begin step(1'b0); if (rd_done) dones++; end
      checks++;
      if (got_q.size() !== exp_q.size() || dones !== 2) begin errors++; $display("FAIL ovf_buffers: got %0d beats %0d dones required %0d/2", got_q.size(), dones, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
      clear_obs(); dones = 0;
      step(1'b1);
      for (int c = 0; c < 60 && dones < 1; c++) begin step(1'b0); if (rd_done) dones++; end
      checks++;
      if (overflow !== 1'b1 || dones !== 1) begin errors++; $display("FAIL ovf_sticky: got ovf=%b dones=%0d required 1/1", overflow, dones); end
      do_reset();
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow); end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      do_reset(); fill_mem(1'b0); clear_obs(); ready_mode = 0;
      step(1'b1);
      for (int c = 0; c < 40 && got_q.size() < 7; c++) step(1'b0);
      ready_mode = 3;
      step(1'b0);
      rst = 1'b1;
      step(1'b0);
      rst = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== 4'd0) begin errors++; $display("FAIL rstmid_state: got v=%b busy=%b addr=%0d required 0/0/0", m_valid, busy, rd_addr); end
      for (int c = 0; c < 20; c++) begin step(1'b0); if (rd_done) dones++; end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL rstmid_nodone: got %0d rd_done pulses required 0", dones); end
      clear_obs(); ready_mode = 0;
      expect_buffer(DEPTH);
      step(1'b1);
      for (int c = 0; c < 60 && dones < 1; c++) begin step(1'b0); if (rd_done) dones++; end
      repeat (3) step(1'b0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d beats required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         int dones = 0;
         int nbuf = 1 + int'($urandom_range(0, 1));
         int gap  = int'($urandom_range(1, 14));
         do_reset(); fill_mem(1'b0); clear_obs(); ready_mode = 2;
         for (int b = 0; b < nbuf; b++) expect_buffer(DEPTH);
         step(1'b1);
         repeat (gap) step(1'b0);
         step(nbuf == 2);
         for (int c = 0; c < 400 && dones < nbuf; c++) begin step(1'b0); if (rd_done) dones++; end
         repeat (3) step(1'b0);
         checks++;
         if (got_q.size() !== exp_q.size() || dones !== nbuf) begin errors++; $display("FAIL rand%0d_count: got %0d beats %0d dones required %0d/%0d", it, got_q.size(), dones, exp_q.size(), nbuf); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h required %h", it, i, got_q[i], exp_q[i]); end
         end
         checks++;
         if (stall_viol !== 0 || max_lead > 2 || overflow !== 1'b0) begin errors++; $display("FAIL rand%0d_misc: got stalls=%0d lead=%0d ovf=%b required 0/<=2/0", it, stall_viol, max_lead, overflow); end
      end
   endtask

`ifdef PINGPONG_RD_LEN_EN
   task automatic test_len();
      int lens [3] = '{5, 0, 20};
      for (int k = 0; k < 3; k++) begin
         int dones = 0;
         int n = (lens[k] > DEPTH) ? DEPTH : lens[k];
         do_reset(); fill_mem(1'b0); clear_obs(); ready_mode = 0;
         expect_buffer(n);
         rd_len = 5'(lens[k]);
         step(1'b1);
         rd_len = 5'd16;
         for (int c = 0; c < 60 && dones < 1; c++) begin step(1'b0); if (rd_done) dones++; end
         repeat (3) step(1'b0);
         checks++;
         if (got_q.size() !== exp_q.size() || dones !== 1) begin errors++; $display("FAIL len%0d_count: got %0d beats %0d dones required %0d/1", lens[k], got_q.size(), dones, exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL len%0d_beat%0d: got %h required %h", lens[k], i, got_q[i], exp_q[i]); end
         end
         if (n == 0) begin
            checks++;
            if (first_valid_cyc !== -1) begin errors++; $display("FAIL len0_novalid: got m_valid at cycle %0d required none", first_valid_cyc); end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_random();
`ifdef PINGPONG_RD_LEN_EN
      test_len();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
